// File: rtl/fusion_window_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fusion_window_buffer
// Description : Sliding-window sample buffer with valid/ready handshake on
//               both sides; emits a flattened WIN-sample window every STRIDE
//               accepted samples. Optional macro FUSION_WINBUF_ZERO_PAD_EN
//               treats the window as zero-filled and full from reset/clr.
// Revision    : 1.0 - initial release
// ============================================================================
module fusion_window_buffer #(
    parameter int DATA_W = 16,
    parameter int WIN    = 10,
    parameter int STRIDE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W*WIN-1:0] out_data
);

    localparam int c_FILL_W = $clog2(WIN + 1);
    localparam int c_STR_W  = $clog2(STRIDE + 1);
    localparam int c_BUS_W  = DATA_W * WIN;

    localparam logic [c_FILL_W-1:0] c_FILL_FULL = c_FILL_W'(WIN);
    localparam logic [c_FILL_W-1:0] c_FILL_LAST = c_FILL_W'(WIN - 1);
    localparam logic [c_STR_W-1:0]  c_STR_LAST  = c_STR_W'(STRIDE - 1);

`ifdef FUSION_WINBUF_ZERO_PAD_EN
    // Start "full" with the stride counter primed so the first accept emits.
    localparam logic [c_FILL_W-1:0] c_FILL_RST = c_FILL_FULL;
    localparam logic [c_STR_W-1:0]  c_STR_RST  = c_STR_LAST;
`else
    localparam logic [c_FILL_W-1:0] c_FILL_RST = '0;
    localparam logic [c_STR_W-1:0]  c_STR_RST  = '0;
`endif

    logic [c_BUS_W-1:0]  r_buf;
    logic [c_FILL_W-1:0] r_fill;
    logic [c_STR_W-1:0]  r_stride;
    logic                r_out_valid;
    logic [c_BUS_W-1:0]  r_out_data;

    logic                w_acc;
    logic                w_emit;
    logic [c_BUS_W-1:0]  w_buf_next;

    // Slice 0 is the oldest sample, so new data enters at the top.
    assign w_buf_next = {in_data, r_buf[c_BUS_W-1:DATA_W]};

    assign in_ready  = ~(r_out_valid & ~out_ready);
    assign w_acc     = in_valid & in_ready;
    assign w_emit    = w_acc & ((r_fill == c_FILL_LAST) |
                                ((r_fill == c_FILL_FULL) & (r_stride == c_STR_LAST)));
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    always_ff @(posedge clk) begin
        if (rst | clr) begin
            r_buf       <= '0;
            r_fill      <= c_FILL_RST;
            r_stride    <= c_STR_RST;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_acc) begin
                r_buf <= w_buf_next;
                if (r_fill != c_FILL_FULL) begin
                    r_fill <= r_fill + c_FILL_W'(1);
                end
                if (r_fill == c_FILL_LAST) begin
                    r_stride <= '0;
                end else if (r_fill == c_FILL_FULL) begin
                    if (r_stride == c_STR_LAST) begin
                        r_stride <= '0;
                    end else begin
                        r_stride <= r_stride + c_STR_W'(1);
                    end
                end
            end
            // A fresh window overrides consumption, so there is no bubble.
            if (w_emit) begin
                r_out_data  <= w_buf_next;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fusion_window_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for fusion_window_buffer: two instances (STRIDE 1 and 4) share
// stimulus and are checked against a sample-history reference model.
module tb_fusion_window_buffer;

    localparam int DW = 16;
    localparam int W  = 10;
    localparam int BW = DW * W;
    localparam int HMAX = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, clr, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic          in_ready1, out_valid1, in_ready4, out_valid4;
    logic [BW-1:0] out_data1, out_data4;

    fusion_window_buffer #(.DATA_W(DW), .WIN(W), .STRIDE(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1)
    );

    fusion_window_buffer #(.DATA_W(DW), .WIN(W), .STRIDE(4)) dut4 (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4)
    );

    int n_pass = 0;
    int n_chk  = 0;

    // Reference model: full history of accepted samples per instance.
    logic [DW-1:0] hist [2][HMAX];
    int            nacc [2];
    bit            ev   [2];
    logic [BW-1:0] ed   [2];
    int            strd [2] = '{1, 4};

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit emit_rule(input int n, input int s);
`ifdef FUSION_WINBUF_ZERO_PAD_EN
        return ((n - 1) % s) == 0;
`else
        return (n >= W) && (((n - W) % s) == 0);
`endif
    endfunction

    task automatic model_edge(input bit rr, input bit cc, input bit v,
                              input logic [DW-1:0] dat, input bit ordy);
        for (int d = 0; d < 2; d++) begin
            if (rr || cc) begin
                nacc[d] = 0;
                ev[d]   = 1'b0;
                ed[d]   = '0;
            end else begin
                bit rdy;
                bit em;
                rdy = !(ev[d] && !ordy);
                em  = 1'b0;
                if (v && rdy) begin
                    hist[d][nacc[d] % HMAX] = dat;
                    nacc[d]++;
                    em = emit_rule(nacc[d], strd[d]);
                end
                if (em) begin
                    for (int k = 0; k < W; k++) begin
                        int j;
                        j = nacc[d] - W + k;
                        ed[d][k*DW +: DW] = (j < 0) ? '0 : hist[d][j % HMAX];
                    end
                    ev[d] = 1'b1;
                end else if (ordy) begin
                    ev[d] = 1'b0;
                end
            end
        end
    endtask

    // One clock: drive on negedge, check ready before the edge, outputs after.
    task automatic step(input bit rr, input bit cc, input bit v,
                        input logic [DW-1:0] dat, input bit ordy);
        @(negedge clk);
        rst = rr; clr = cc; in_valid = v; in_data = dat; out_ready = ordy;
        #1;
        if (!rr) begin
            chk("in_ready1", BW'(in_ready1), BW'(!(ev[0] && !ordy)));
            chk("in_ready4", BW'(in_ready4), BW'(!(ev[1] && !ordy)));
        end
        @(posedge clk);
        model_edge(rr, cc, v, dat, ordy);
        #1;
        chk("out_valid1", BW'(out_valid1), BW'(ev[0]));
        chk("out_data1",  out_data1, ed[0]);
        chk("out_valid4", BW'(out_valid4), BW'(ev[1]));
        chk("out_data4",  out_data4, ed[1]);
    endtask

    function automatic logic [DW-1:0] sl(input logic [BW-1:0] bus, input int k);
        return bus[k*DW +: DW];
    endfunction

    typedef struct {
        bit            v;
        logic [DW-1:0] d;
        bit            ordy;
        bit            exp_v;
        logic [DW-1:0] exp_lo;
        logic [DW-1:0] exp_hi;
    } vec_t;

    vec_t tbl[12];
    logic [DW-1:0] lo4 [$];
    logic [DW-1:0] exp_lo4 [$];

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

        for (int i = 0; i < 12; i++) begin
            int n;
            n = i + 1;
            tbl[i].v = 1'b1; tbl[i].d = DW'(n); tbl[i].ordy = 1'b1;
            tbl[i].exp_hi = DW'(n);
`ifdef FUSION_WINBUF_ZERO_PAD_EN
            tbl[i].exp_v  = 1'b1;
            tbl[i].exp_lo = (n >= W) ? DW'(n - 9) : '0;
`else
            tbl[i].exp_v  = (n >= W);
            tbl[i].exp_lo = DW'(n - 9);
`endif
        end

        // Reset state
        step(1, 0, 0, '0, 1);
        step(1, 0, 0, '0, 1);
        chk("rst_out_valid", BW'(out_valid1), BW'(0));
        chk("rst_out_data",  out_data1, '0);
        chk("rst_in_ready",  BW'(in_ready1), BW'(1));

        // Continuous feed 1..12, table-driven
        for (int i = 0; i < 12; i++) begin
            step(0, 0, tbl[i].v, tbl[i].d, tbl[i].ordy);
            chk("tbl_valid", BW'(out_valid1), BW'(tbl[i].exp_v));
            if (tbl[i].exp_v) begin
                chk("tbl_oldest", BW'(sl(out_data1, 0)), BW'(tbl[i].exp_lo));
                chk("tbl_newest", BW'(sl(out_data1, W-1)), BW'(tbl[i].exp_hi));
            end
        end

        // STRIDE=4: record the oldest slice of every window pulse for 1..18
        step(1, 0, 0, '0, 1);
        for (int i = 1; i <= 18; i++) begin
            step(0, 0, 1, DW'(i), 1);
            if (out_valid4) lo4.push_back(sl(out_data4, 0));
        end
`ifdef FUSION_WINBUF_ZERO_PAD_EN
        exp_lo4 = '{16'd0, 16'd0, 16'd0, 16'd4, 16'd8};
`else
        exp_lo4 = '{16'd1, 16'd5, 16'd9};
`endif
        chk("stride4_count", BW'(lo4.size()), BW'(exp_lo4.size()));
        for (int i = 0; i < exp_lo4.size() && i < lo4.size(); i++)
            chk("stride4_oldest", BW'(lo4[i]), BW'(exp_lo4[i]));

        // Back-pressure
        step(1, 0, 0, '0, 1);
        for (int i = 1; i <= 10; i++) step(0, 0, 1, DW'(i), 1);
        for (int c = 0; c < 2; c++) begin
            step(0, 0, 1, 16'd11, 0);
            chk("bp_in_ready", BW'(in_ready1), BW'(0));
            chk("bp_hold_valid", BW'(out_valid1), BW'(1));
            chk("bp_hold_newest", BW'(sl(out_data1, W-1)), BW'(10));
            chk("bp_hold_oldest", BW'(sl(out_data1, 0)), BW'(1));
        end
        step(0, 0, 1, 16'd11, 1);
        chk("bp_next_valid", BW'(out_valid1), BW'(1));
        chk("bp_next_oldest", BW'(sl(out_data1, 0)), BW'(2));
        chk("bp_next_newest", BW'(sl(out_data1, W-1)), BW'(11));

        // Signed extremes as last three samples
        step(1, 0, 0, '0, 1);
        for (int i = 1; i <= 7; i++) step(0, 0, 1, DW'(i), 1);
        step(0, 0, 1, 16'h8000, 1);
        step(0, 0, 1, 16'h7FFF, 1);
        step(0, 0, 1, 16'hFFFF, 1);
        chk("signed_s7", BW'(sl(out_data1, 7)), BW'(16'h8000));
        chk("signed_s8", BW'(sl(out_data1, 8)), BW'(16'h7FFF));
        chk("signed_s9", BW'(sl(out_data1, 9)), BW'(16'hFFFF));

        // clr mid-record, then 100..109
        step(1, 0, 0, '0, 1);
        for (int i = 1; i <= 7; i++) step(0, 0, 1, DW'(i), 1);
        step(0, 1, 1, 16'd55, 1);
        for (int i = 100; i <= 109; i++) begin
            step(0, 0, 1, DW'(i), 1);
`ifndef FUSION_WINBUF_ZERO_PAD_EN
            if (i == 108) chk("clr_no_early", BW'(out_valid1), BW'(0));
`endif
        end
        chk("clr_valid",  BW'(out_valid1), BW'(1));
        chk("clr_oldest", BW'(sl(out_data1, 0)), BW'(100));
        chk("clr_newest", BW'(sl(out_data1, W-1)), BW'(109));

        // clr while a window is pending
        step(0, 1, 0, '0, 0);
        chk("clr_pending", BW'(out_valid1), BW'(0));

`ifdef FUSION_WINBUF_ZERO_PAD_EN
        step(1, 0, 0, '0, 1);
        step(0, 0, 1, 16'd5, 1);
        chk("pad_valid", BW'(out_valid1), BW'(1));
        chk("pad_window", out_data1, BW'(5) << (DW * (W - 1)));
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            bit rr, cc, v, o;
            rr = ($urandom % 300) == 0;
            cc = ($urandom % 60) == 0;
            v  = ($urandom % 4) != 0;
            o  = ($urandom % 3) != 0;
            step(rr, cc, v, DW'($urandom), o);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
